// File: rtl/popcount_pkg.sv
// Shared types and defaults for the frame popcount sequencer.
// The width-check macro compares a register width against the largest value it must hold.
`ifndef POPCOUNT_FITS
`define POPCOUNT_FITS(w, limit) ((64'd1 << (w)) > 64'(limit))
`endif

package popcount_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        HOLD  = ST_HOLD
    } state_e;

    localparam int MAX_BYTES_DEF = 32;
    localparam int CNT_W_DEF     = 9;
    localparam int BYTE_W_DEF    = 6;

endpackage

// File: rtl/popcount8_core.sv
// Combinational popcount of one byte as a balanced adder tree (pairs, quads, final sum).
module popcount8_core (
    input  logic [7:0] d,
    output logic [3:0] pc
);

    logic [3:0][1:0] sum2;
    logic [1:0][2:0] sum4;

    for (genvar i = 0; i < 4; i++) begin : g_pair
        assign sum2[i] = 2'(d[2*i]) + 2'(d[2*i+1]);
    end

    for (genvar j = 0; j < 2; j++) begin : g_quad
        assign sum4[j] = 3'(sum2[2*j]) + 3'(sum2[2*j+1]);
    end

    assign pc = 4'(sum4[0]) + 4'(sum4[1]);

endmodule

// File: rtl/popcount_frame_seq.sv
// Accumulates the set-bit total of each byte frame and holds the result on a valid/ready port.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; ready never depends on valid.
module popcount_frame_seq
    import popcount_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int BYTE_W    = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [BYTE_W-1:0] out_bytes,
    output logic              out_trunc,
    output state_e            dbg_state_o
);

    if (MAX_BYTES < 1 || MAX_BYTES > 255) begin : g_bad_max
        $error("MAX_BYTES must be in 1..255");
    end
    if (!`POPCOUNT_FITS(CNT_W, 8 * MAX_BYTES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for 8*MAX_BYTES");
    end
    if (!`POPCOUNT_FITS(BYTE_W, MAX_BYTES)) begin : g_bad_byte_w
        $error("BYTE_W too narrow for MAX_BYTES");
    end

    state_e              state_q;
    logic [CNT_W-1:0]    acc_q;
    logic [BYTE_W-1:0]   bytes_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                trunc_q;

    logic [3:0]          pc;
    logic [CNT_W-1:0]    pc_d;
    logic [CNT_W-1:0]    acc_sum_d;
    logic [BYTE_W-1:0]   bytes_inc_d;
    logic                accept;
    logic                limit_hit_d;

    popcount8_core u_core (
        .d  (in_data),
        .pc (pc)
    );

    assign accept      = in_valid & in_ready_q;
    assign pc_d        = CNT_W'(pc);
    assign acc_sum_d   = acc_q + pc_d;
    assign bytes_inc_d = bytes_q + BYTE_W'(1);
    // Limit test on the post-increment count, so IDLE's first byte compares against 1.
    assign limit_hit_d = (state_q == IDLE) ? (MAX_BYTES == 1)
                                           : (bytes_inc_d == BYTE_W'(MAX_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            bytes_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            trunc_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q   <= (state_q == IDLE) ? pc_d : acc_sum_d;
                        bytes_q <= (state_q == IDLE) ? BYTE_W'(1) : bytes_inc_d;
                        if (in_last || limit_hit_d) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            trunc_q     <= ~in_last;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        bytes_q     <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        trunc_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    bytes_q     <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    trunc_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_count   = acc_q;
    assign out_bytes   = bytes_q;
    assign out_trunc   = trunc_q;
    assign dbg_state_o = state_q;

endmodule
